uart_rx_mv: RTL and testbench

Parametrised next-generation UART receiver for the UART IP's RX path.
- Frames 5–9 data bits with none, odd, even, stick-0 or stick-1 parity, and 1 or 2 stop bits.
- Decides each bit by a 3-sample majority vote around mid-bit.
- Holds one received word plus its error flags in an output register with a valid/ready handshake toward the RX FIFO.
- Adds break detection, idle-gap timeout and mid-frame abort.

---
 rtl/uart_rx_pkg.sv | 36 +++
 rtl/rx_sync_vote.sv | 50 +++++
 rtl/uart_rx_mv.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_rx_mv.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the majority-vote UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP1    = 3'd4,
        S_STOP2    = 3'd5,
        S_BRK_WAIT = 3'd6
    } state_e;

    // Low two bits of parity_sel; bit 2 enables parity.
    typedef enum logic [1:0] {
        PAR_ODD    = 2'b00,
        PAR_EVEN   = 2'b01,
        PAR_STICK0 = 2'b10,
        PAR_STICK1 = 2'b11
    } parity_sel_e;

    function automatic int width_dec(input logic [2:0] sel, input int max_w);
        int w;
        w = (sel <= 3'd4) ? int'(sel) + 5 : 8;
        return (w > max_w) ? max_w : w;
    endfunction

    function automatic int mid_lo(input int ov);
        return ov / 2 - 1;
    endfunction

    function automatic int mid_hi(input int ov);
        return ov / 2 + 1;
    endfunction

endpackage

// File: rtl/rx_sync_vote.sv
// RX synchroniser, falling-edge detect and 3-sample mid-bit majority vote.
module rx_sync_vote
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OV_SAMP     = 16,
    parameter int CW          = $clog2(OV_SAMP)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx,
    input  logic          i_baud,
    input  logic [CW-1:0] i_cnt,
    output logic          o_rx_s,
    output logic          o_fall,
    output logic          o_vote
);
    localparam logic [CW-1:0] C_LO = CW'(mid_lo(OV_SAMP));
    localparam logic [CW-1:0] C_HI = CW'(mid_hi(OV_SAMP));

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [1:0]             samp_q, samp_d;
    logic                   win;

    assign o_rx_s = sync_q[SYNC_STAGES-1];
    assign o_fall = prev_q & ~o_rx_s;
    // The third sample is the live one, so the vote is ready on the M+1 tick itself.
    assign o_vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & o_rx_s) | (samp_q[0] & o_rx_s);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_rx};
        prev_d = o_rx_s;
        win    = i_baud && (i_cnt >= C_LO) && (i_cnt <= C_HI);
        samp_d = win ? {samp_q[0], o_rx_s} : samp_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            samp_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            samp_q <= samp_d;
        end
    end

endmodule

// File: rtl/uart_rx_mv.sv
// UART receiver: frame FSM, bit timing, parity check, output register and idle timer.
//   state      | meaning
//   S_IDLE     | waiting for a start edge
//   S_START    | start bit, noise rejected by vote
//   S_DATA     | data bits, LSB first
//   S_PARITY   | parity bit
//   S_STOP1    | first stop bit, break decided here
//   S_STOP2    | second stop bit
//   S_BRK_WAIT | break reported, waiting for line high
module uart_rx_mv
    import uart_rx_pkg::*;
#(
    parameter int OV_SAMP     = 16,
    parameter int MAX_W       = 9,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_BITS   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_baud,
    input  logic             i_rx,
    input  logic             i_rx_en,
    input  logic [2:0]       i_parity_sel,
    input  logic             i_stop_sel,
    input  logic [2:0]       i_width_sel,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [MAX_W-1:0] o_data,
    output logic             o_error_frame,
    output logic             o_error_parity,
    output logic             o_break,
    output logic             o_error_overrun,
    output logic             o_idle_timeout,
    output logic             o_busy
);
    localparam int CW = $clog2(OV_SAMP);
    localparam int IW = $clog2(MAX_W);
    localparam int BW = $clog2(IDLE_BITS);
    localparam logic [CW-1:0] C_DEC = CW'(mid_hi(OV_SAMP));
    localparam logic [CW-1:0] C_END = CW'(OV_SAMP - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d, last_q, last_d;
    logic [2:0]         psel_q, psel_d;
    logic               stop2_q, stop2_d;
    logic [MAX_W-1:0]   shift_q, shift_d;
    logic               pbit_q, pbit_d, perr_q, perr_d, s1err_q, s1err_d;
    logic               valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, brk_q, brk_d;
    logic [MAX_W-1:0]   data_q, data_d;
    logic               ovr_q, ovr_d, tmo_q, tmo_d, armed_q, armed_d;
    logic [CW-1:0]      itick_q, itick_d;
    logic [BW-1:0]      ibit_q, ibit_d;

    logic rx_s, fall, vote;
    logic tick_end, dec, par_en, brk, comp, comp_frame, comp_break;

    rx_sync_vote #(
        .SYNC_STAGES (SYNC_STAGES),
        .OV_SAMP     (OV_SAMP)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_rx   (i_rx),
        .i_baud (i_baud),
        .i_cnt  (cnt_q),
        .o_rx_s (rx_s),
        .o_fall (fall),
        .o_vote (vote)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            psel_q  <= '0;
            stop2_q <= 1'b0;
            shift_q <= '0;
            pbit_q  <= 1'b0;
            perr_q  <= 1'b0;
            s1err_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
            armed_q <= 1'b0;
            itick_q <= '0;
            ibit_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            psel_q  <= psel_d;
            stop2_q <= stop2_d;
            shift_q <= shift_d;
            pbit_q  <= pbit_d;
            perr_q  <= perr_d;
            s1err_q <= s1err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
            armed_q <= armed_d;
            itick_q <= itick_d;
            ibit_q  <= ibit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (i_rx_en && fall) state_d = S_START;
            S_START:    if (dec && vote) state_d = S_IDLE;
                        else if (tick_end) state_d = S_DATA;
            S_DATA:     if (tick_end && idx_q == last_q) state_d = par_en ? S_PARITY : S_STOP1;
            S_PARITY:   if (tick_end) state_d = S_STOP1;
            S_STOP1:    if (dec) begin
                            if (brk) state_d = S_BRK_WAIT;
                            else if (!stop2_q) state_d = S_IDLE;
                        end else if (tick_end) begin
                            state_d = S_STOP2;
                        end
            S_STOP2:    if (dec) state_d = S_IDLE;
            S_BRK_WAIT: if (rx_s) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !i_rx_en) state_d = S_IDLE;
    end

    always_comb begin
        tick_end   = i_baud && (cnt_q == C_END);
        dec        = i_baud && (cnt_q == C_DEC);
        par_en     = psel_q[2];
        brk        = (shift_q == '0) && (!par_en || !pbit_q) && !vote;
        comp       = 1'b0;
        comp_frame = 1'b0;
        comp_break = 1'b0;
        if (i_rx_en && dec) begin
            if (state_q == S_STOP1) begin
                if (brk) begin
                    comp       = 1'b1;
                    comp_frame = 1'b1;
                    comp_break = 1'b1;
                end else if (!stop2_q) begin
                    comp       = 1'b1;
                    comp_frame = !vote;
                end
            end else if (state_q == S_STOP2) begin
                comp       = 1'b1;
                comp_frame = s1err_q | !vote;
            end
        end
        o_busy = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        psel_d  = psel_q;
        stop2_d = stop2_q;
        shift_d = shift_q;
        pbit_d  = pbit_q;
        perr_d  = perr_q;
        s1err_d = s1err_q;
        if (i_baud) cnt_d = (cnt_q == C_END) ? '0 : cnt_q + 1'b1;
        if (state_q == S_IDLE || state_d == S_IDLE || state_d == S_BRK_WAIT) cnt_d = '0;
        case (state_q)
            S_IDLE: if (state_d == S_START) begin
                last_d  = IW'(width_dec(i_width_sel, MAX_W) - 1);
                psel_d  = i_parity_sel;
                stop2_d = i_stop_sel;
                shift_d = '0;
                idx_d   = '0;
                pbit_d  = 1'b0;
                perr_d  = 1'b0;
                s1err_d = 1'b0;
            end
            S_DATA: begin
                if (dec) shift_d[idx_q] = vote;
                if (tick_end && idx_q != last_q) idx_d = idx_q + 1'b1;
            end
            S_PARITY: if (dec) begin
                pbit_d = vote;
                case (parity_sel_e'(psel_q[1:0]))
                    PAR_ODD:    perr_d = ~(^shift_q ^ vote);
                    PAR_EVEN:   perr_d = ^shift_q ^ vote;
                    PAR_STICK0: perr_d = vote;
                    PAR_STICK1: perr_d = !vote;
                    default:    perr_d = 1'b0;
                endcase
            end
            S_STOP1: if (dec) s1err_d = !vote;
            default: ;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        brk_d   = brk_q;
        ovr_d   = 1'b0;
        if (comp) begin
            if (!valid_q || i_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
                fe_d    = comp_frame;
                pe_d    = perr_q;
                brk_d   = comp_break;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        armed_d = armed_q;
        itick_d = itick_q;
        ibit_d  = ibit_q;
        tmo_d   = 1'b0;
        if (comp) begin
            armed_d = 1'b1;
            itick_d = '0;
            ibit_d  = '0;
        end else if (state_q == S_IDLE && state_d == S_START) begin
            itick_d = '0;
            ibit_d  = '0;
        end else if (armed_q && state_q == S_IDLE && rx_s && i_baud) begin
            if (itick_q == C_END) begin
                itick_d = '0;
                if (ibit_q == BW'(IDLE_BITS - 1)) begin
                    tmo_d   = 1'b1;
                    armed_d = 1'b0;
                    ibit_d  = '0;
                end else begin
                    ibit_d = ibit_q + 1'b1;
                end
            end else begin
                itick_d = itick_q + 1'b1;
            end
        end
    end

    assign o_valid         = valid_q;
    assign o_data          = data_q;
    assign o_error_frame   = fe_q;
    assign o_error_parity  = pe_q;
    assign o_break         = brk_q;
    assign o_error_overrun = ovr_q;
    assign o_idle_timeout  = tmo_q;

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed bench for uart_rx_mv: hand-built frames with hand-computed results.
module tb_uart_rx_mv;
    localparam int OV    = 16;
    localparam int SYNC  = 2;
    localparam int IDLEB = 4;
    localparam int BIT   = 2 * OV;

    logic       clk = 1'b0;
    logic       rst, baud, rx, rx_en, stop_sel, ready;
    logic [2:0] par_sel, width_sel;
    logic       valid, fe, pe, brk, ovr, tmo, busy;
    logic [8:0] data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int xfer_cnt = 0, ovr_cnt = 0, tmo_cnt = 0, rise_cyc = 0;
    logic       valid_prev = 1'b0;
    logic [8:0] x_data = '0;
    logic       x_fe = 1'b0, x_pe = 1'b0, x_brk = 1'b0;

    uart_rx_mv #(
        .OV_SAMP     (OV),
        .MAX_W       (9),
        .SYNC_STAGES (SYNC),
        .IDLE_BITS   (IDLEB)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_baud          (baud),
        .i_rx            (rx),
        .i_rx_en         (rx_en),
        .i_parity_sel    (par_sel),
        .i_stop_sel      (stop_sel),
        .i_width_sel     (width_sel),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_data          (data),
        .o_error_frame   (fe),
        .o_error_parity  (pe),
        .o_break         (brk),
        .o_error_overrun (ovr),
        .o_idle_timeout  (tmo),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ovr) ovr_cnt++;
        if (tmo) tmo_cnt++;
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
        if (valid && ready) begin
            xfer_cnt++;
            x_data = data;
            x_fe   = fe;
            x_pe   = pe;
            x_brk  = brk;
        end
    end

    initial begin
        baud = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            baud = ~baud;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gbit selects a bit that gets a 2-clock (one tick) inverted glitch near mid-bit.
    task automatic send_bits(input logic [15:0] b, input int n, input int gbit);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < BIT; j++) begin
                rx = (i == gbit && j >= 16 && j < 18) ? ~b[i] : b[i];
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int w, input int par,
                              input logic s1, input logic s2, input int ns, input int gbit);
        logic [15:0] b;
        int n;
        b = '1;
        n = 0;
        b[n] = 1'b0;
        n++;
        for (int i = 0; i < w; i++) begin
            b[n] = d[i];
            n++;
        end
        if (par >= 0) begin
            b[n] = (par != 0);
            n++;
        end
        b[n] = s1;
        n++;
        if (ns == 2) begin
            b[n] = s2;
            n++;
        end
        send_bits(b, n, gbit);
    endtask

    initial begin
        int base, obase, tbase, t0, lat;
        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; ready = 1'b1;
        par_sel = 3'b000; stop_sel = 1'b0; width_sel = 3'd3;
        wait_clk(4);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_flags", 32'({fe, pe, brk, ovr, tmo, busy}), 0);
        rst = 1'b0;
        wait_clk(2 * BIT);

        // 8N1 0xA5
        base = xfer_cnt;
        t0 = cyc;
        send_frame(9'h0A5, 8, -1, 1'b1, 1'b1, 1, -1);
        wait_clk(2 * BIT);
        check("t1_words", 32'(xfer_cnt - base), 1);
        check("t1_data", 32'(x_data), 32'h0A5);
        check("t1_flags", 32'({x_fe, x_pe, x_brk}), 0);
        lat = rise_cyc - t0;
        n_tests++;
        assert (lat >= 304 + SYNC && lat <= 304 + SYNC + 10) else begin
            n_fail++;
            $error("FAIL t1_latency: observed %0d cycles, required %0d..%0d", lat, 304 + SYNC, 314 + SYNC);
        end

        // 9E2 0x1FF: wrong parity, then good parity with second stop low
        width_sel = 3'd4; par_sel = 3'b101; stop_sel = 1'b1;
        base = xfer_cnt;
        send_frame(9'h1FF, 9, 0, 1'b1, 1'b1, 2, -1);
        wait_clk(BIT);
        check("t2a_words", 32'(xfer_cnt - base), 1);
        check("t2a_data", 32'(x_data), 32'h1FF);
        check("t2a_perr", 32'(x_pe), 1);
        check("t2a_ferr_brk", 32'({x_fe, x_brk}), 0);
        send_frame(9'h1FF, 9, 1, 1'b1, 1'b0, 2, -1);
        rx = 1'b1;
        wait_clk(BIT);
        check("t2b_words", 32'(xfer_cnt - base), 2);
        check("t2b_data", 32'(x_data), 32'h1FF);
        check("t2b_perr", 32'(x_pe), 0);
        check("t2b_ferr", 32'(x_fe), 1);

        // glitches: one-tick low pulse as false start, then glitch inside a data bit
        width_sel = 3'd3; par_sel = 3'b000; stop_sel = 1'b0;
        base = xfer_cnt;
        rx = 1'b0;
        wait_clk(2);
        rx = 1'b1;
        wait_clk(8);
        check("t3_busy_false_start", 32'(busy), 1);
        wait_clk(32);
        check("t3_busy_back_idle", 32'(busy), 0);
        wait_clk(11 * BIT);
        check("t3_no_word", 32'(xfer_cnt - base), 0);
        check("t3_valid", 32'(valid), 0);
        send_frame(9'h03C, 8, -1, 1'b1, 1'b1, 1, 2);
        wait_clk(BIT);
        check("t3_glitch_words", 32'(xfer_cnt - base), 1);
        check("t3_glitch_data", 32'(x_data), 32'h03C);

        // overrun with consumer stalled
        ready = 1'b0;
        base = xfer_cnt;
        obase = ovr_cnt;
        send_frame(9'h011, 8, -1, 1'b1, 1'b1, 1, -1);
        send_frame(9'h022, 8, -1, 1'b1, 1'b1, 1, -1);
        wait_clk(BIT);
        check("t4_valid_held", 32'(valid), 1);
        check("t4_data_held", 32'(data), 32'h011);
        check("t4_overrun", 32'(ovr_cnt - obase), 1);
        check("t4_no_xfer", 32'(xfer_cnt - base), 0);
        ready = 1'b1;
        wait_clk(1);
        check("t4_valid_fall", 32'(valid), 0);
        check("t4_xfer", 32'(xfer_cnt - base), 1);
        check("t4_xfer_data", 32'(x_data), 32'h011);
        wait_clk(BIT);
        check("t4_xfer_once", 32'(xfer_cnt - base), 1);

        // 7E1 break, then 0x55
        width_sel = 3'd2; par_sel = 3'b101; stop_sel = 1'b0;
        base = xfer_cnt;
        rx = 1'b0;
        wait_clk(20 * BIT);
        check("t5_brk_words", 32'(xfer_cnt - base), 1);
        check("t5_brk_data", 32'(x_data), 0);
        check("t5_brk_flags", 32'({x_brk, x_fe, x_pe}), 32'b110);
        check("t5_brk_wait_busy", 32'(busy), 1);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("t5_idle_after_brk", 32'(busy), 0);
        send_frame(9'h055, 7, 0, 1'b1, 1'b1, 1, -1);
        wait_clk(BIT);
        check("t5_words", 32'(xfer_cnt - base), 2);
        check("t5_data", 32'(x_data), 32'h055);
        check("t5_flags", 32'({x_brk, x_fe, x_pe}), 0);

        // abort mid-DATA
        width_sel = 3'd3; par_sel = 3'b000; stop_sel = 1'b0;
        base = xfer_cnt;
        send_bits(16'h0002, 3, -1);
        check("t6_busy_in_data", 32'(busy), 1);
        rx_en = 1'b0;
        wait_clk(1);
        check("t6_abort_busy", 32'(busy), 0);
        send_bits(16'h005B, 7, -1);
        rx = 1'b1;
        wait_clk(BIT);
        rx_en = 1'b1;
        wait_clk(8 * BIT);
        check("t6_abort_no_word", 32'(xfer_cnt - base), 0);
        check("t6_abort_valid", 32'(valid), 0);

        // idle timeout after a frame (4 bit times)
        tbase = tmo_cnt;
        send_frame(9'h05A, 8, -1, 1'b1, 1'b1, 1, -1);
        wait_clk(BIT * 5 / 2);
        check("t6_frame_word", 32'(x_data), 32'h05A);
        check("t6_tmo_early", 32'(tmo_cnt - tbase), 0);
        wait_clk(6 * BIT);
        check("t6_tmo_once", 32'(tmo_cnt - tbase), 1);

        // reset mid-frame with a held word
        ready = 1'b0;
        send_frame(9'h081, 8, -1, 1'b1, 1'b1, 1, -1);
        wait_clk(BIT);
        check("t6_held_valid", 32'(valid), 1);
        send_bits(16'h0006, 4, -1);
        check("t6_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        wait_clk(1);
        check("t6_rst_valid", 32'(valid), 0);
        check("t6_rst_data", 32'(data), 0);
        check("t6_rst_flags", 32'({fe, pe, brk, ovr, tmo, busy}), 0);
        rx = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        ready = 1'b1;
        wait_clk(2 * BIT);
        check("t6_post_rst_idle", 32'({valid, busy}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
